mips_mc_controller: RTL and testbench

Control unit for the multicycle MIPS datapath. It sits at the other end of the ALU control interface and sequences one shared ALU and one unified memory across cycles. It drives alucontrol and the datapath mux selects and write enables, and it consumes the ALU zero flag and a memory ready handshake. Branch polarity for beq/bne is resolved inside this block; the ALU zero output is consumed raw.

---
 rtl/mips_mc_controller_pkg.sv | 57 +++++
 rtl/mips_mc_controller_if.sv | 35 +++
 rtl/mips_mc_controller_aludec.sv | 35 +++
 rtl/mips_mc_controller.sv | 167 ++++++++++++++++
 tb/tb_mips_mc_controller.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, function
// codes, ALU control encodings and the FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // {invert_b, sel[1:0]}
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
  endfunction

  // States whose exit to FETCH completes an instruction.
  function automatic logic is_retire_state(input state_t s);
    return s inside {S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_BNEEX, S_ADDIWB, S_JEX};
  endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control-unit <-> datapath bundle. The master side is the controller, the
// slave side is the datapath that supplies op/funct/zero/memready.
interface mips_mc_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             memready;
  logic [2:0]       alucontrol;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic             iord;
  logic             regdst;
  logic             memtoreg;
  logic             irwrite;
  logic             regwrite;
  logic             memwrite;
  logic             pcen;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct, zero, memready,
    output alucontrol, alusrca, alusrcb, pcsrc, iord, regdst, memtoreg,
           irwrite, regwrite, memwrite, pcen, illegal, instret
  );

  modport slave (
    output op, funct, zero, memready,
    input  alucontrol, alusrca, alusrcb, pcsrc, iord, regdst, memtoreg,
           irwrite, regwrite, memwrite, pcen, illegal, instret
  );
endinterface

// File: rtl/mips_mc_controller_aludec.sv
// ALU decoder: turns the FSM's coarse ALU request plus the R-type funct field
// into the 3-bit ALU control word, flagging unsupported funct codes.
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_bad
);

  always_comb begin
    alucontrol = ALU_ADD;
    funct_bad  = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: begin
            alucontrol = ALU_ADD;
            funct_bad  = 1'b1;
          end
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences the shared ALU and unified memory,
// resolves beq/bne polarity and counts retired instructions.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mc_controller_if.master bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  aluop_t     aluop;
  logic [2:0] alucontrol;
  logic       funct_bad;

  logic       alusrca_c;
  logic [1:0] alusrcb_c;
  logic [1:0] pcsrc_c;
  logic       iord_c;
  logic       regdst_c;
  logic       memtoreg_c;
  logic       irwrite_c;
  logic       regwrite_c;
  logic       memwrite_c;
  logic       pcen_c;
  logic       illegal_c;

  mips_aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol),
    .funct_bad  (funct_bad)
  );

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (is_retire_state(state_q) && (state_d == S_FETCH))
      instret_d = instret_q + CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (bus.memready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_BNE:       state_d = S_BNEEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.memready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (bus.memready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_BNEEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output logic; only FETCH/branch strobes and the illegal flags look at inputs
  always_comb begin
    aluop      = ALUOP_ADD;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    pcsrc_c    = 2'b00;
    iord_c     = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    memwrite_c = 1'b0;
    pcen_c     = 1'b0;
    illegal_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb_c = 2'b01;
        irwrite_c = bus.memready;
        pcen_c    = bus.memready;
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        illegal_c = ~op_supported(bus.op);
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
      end
      S_MEMRD: iord_c = 1'b1;
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
      end
      S_RTYPEEX: begin
        aluop     = ALUOP_FUNCT;
        alusrca_c = 1'b1;
        illegal_c = funct_bad;
      end
      S_RTYPEWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        aluop     = ALUOP_SUB;
        alusrca_c = 1'b1;
        pcsrc_c   = 2'b01;
        pcen_c    = (state_q == S_BEQEX) ? bus.zero : ~bus.zero;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_JEX: begin
        pcsrc_c = 2'b10;
        pcen_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alucontrol = alucontrol;
  assign bus.alusrca    = alusrca_c;
  assign bus.alusrcb    = alusrcb_c;
  assign bus.pcsrc      = pcsrc_c;
  assign bus.iord       = iord_c;
  assign bus.regdst     = regdst_c;
  assign bus.memtoreg   = memtoreg_c;
  // Strobes are masked by reset so nothing writes while it is held low.
  assign bus.irwrite    = irwrite_c  & reset;
  assign bus.regwrite   = regwrite_c & reset;
  assign bus.memwrite   = memwrite_c & reset;
  assign bus.pcen       = pcen_c     & reset;
  assign bus.illegal    = illegal_c  & reset;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: each instruction is expanded into its expected
// per-cycle control words from the instruction-level description and compared.
module tb_mips_mc_controller;

  typedef struct packed {
    logic [2:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       pcen;
    logic       illegal;
  } ctl_t;

  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000, T_J = 6'b000010;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_mc_controller_if #(.CNT_W(32)) bus ();
  mips_mc_controller_if #(.CNT_W(4))  bus4 ();

  mips_mc_controller #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  mips_mc_controller #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  assign bus4.op       = bus.op;
  assign bus4.funct    = bus.funct;
  assign bus4.zero     = bus.zero;
  assign bus4.memready = bus.memready;

  ctl_t obs;
  assign obs = {bus.alucontrol, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.iord,
                bus.regdst, bus.memtoreg, bus.irwrite, bus.regwrite,
                bus.memwrite, bus.pcen, bus.illegal};

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  longint unsigned model_ret = 0;

  ctl_t exp_q[$];
  logic mr_q[$];
  ctl_t obs_q[$];

  function automatic ctl_t base();
    ctl_t c;
    c = '0;
    c.alu = 3'b010;
    return c;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic void push(input ctl_t c, input logic mr);
    exp_q.push_back(c);
    mr_q.push_back(mr);
  endfunction

  // A memory-handshake phase: 'waits' stalled cycles then the completing one.
  function automatic void push_wait(input ctl_t stall, input ctl_t done, input int waits);
    for (int i = 0; i < waits; i++) push(stall, 1'b0);
    push(done, 1'b1);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction; returns 1 if it retires.
  function automatic bit build(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int fw, input int mw);
    ctl_t c, d;
    bit known;
    exp_q.delete();
    mr_q.delete();
    known = op inside {T_LW, T_SW, T_R, T_BEQ, T_BNE, T_ADDI, T_J};
    c = base(); c.srcb = 2'b01;
    d = c; d.irwrite = 1'b1; d.pcen = 1'b1;
    push_wait(c, d, fw);
    c = base(); c.srcb = 2'b11; c.illegal = !known;
    push(c, 1'($urandom));
    if (op == T_LW || op == T_SW) begin
      c = base(); c.srca = 1'b1; c.srcb = 2'b10;
      push(c, 1'($urandom));
      c = base(); c.iord = 1'b1;
      if (op == T_SW) c.memwrite = 1'b1;
      push_wait(c, c, mw);
      if (op == T_LW) begin
        c = base(); c.memtoreg = 1'b1; c.regwrite = 1'b1;
        push(c, 1'($urandom));
      end
    end else if (op == T_R) begin
      c = base(); c.srca = 1'b1; c.alu = ref_alu(fn);
      c.illegal = !(fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
      push(c, 1'($urandom));
      c = base(); c.regdst = 1'b1; c.regwrite = 1'b1;
      push(c, 1'($urandom));
    end else if (op == T_BEQ || op == T_BNE) begin
      c = base(); c.alu = 3'b110; c.srca = 1'b1; c.pcsrc = 2'b01;
      c.pcen = (op == T_BEQ) ? z : !z;
      push(c, 1'($urandom));
    end else if (op == T_ADDI) begin
      c = base(); c.srca = 1'b1; c.srcb = 2'b10;
      push(c, 1'($urandom));
      c = base(); c.regwrite = 1'b1;
      push(c, 1'($urandom));
    end else if (op == T_J) begin
      c = base(); c.pcsrc = 2'b10; c.pcen = 1'b1;
      push(c, 1'($urandom));
    end
    return known;
  endfunction

  // Drives the first n queued cycles, recording observed outputs. Starts and
  // ends 1 time unit after a rising edge.
  task automatic run_seq(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      bus.memready = mr_q[i];
      @(negedge clk);
      obs_q.push_back(obs);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.memready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_ret = 0;
  endtask

  task automatic test_reset();
    ctl_t c;
    reset = 1'b0;
    bus.op = T_LW; bus.funct = 6'b0; bus.zero = 1'b0; bus.memready = 1'b1;
    c = base(); c.srcb = 2'b01;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (obs !== c || bus.instret !== 32'd0 || bus4.instret !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_hold: got ctl=%h instret=%0d/%0d, need ctl=%h instret=0", obs, bus.instret, bus4.instret, c);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_ret = 0;
  endtask

  task automatic test_lw();
    bit r;
    bus.op = T_LW; bus.zero = 1'b0;
    r = build(T_LW, 6'b0, 1'b0, 0, 0);
    run_seq(exp_q.size());
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL lw cycle %0d: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (r) model_ret++;
    vectors++;
    if (bus.instret !== 32'd1) begin
      miscompares++;
      $display("FAIL lw_instret: got %0d, need 1", bus.instret);
    end
  endtask

  task automatic test_sw_wait();
    bit r;
    bus.op = T_SW;
    r = build(T_SW, 6'b0, 1'b0, 1, 2);
    run_seq(exp_q.size());
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL sw_wait cycle %0d: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (r) model_ret++;
    vectors++;
    if (bus.instret !== model_ret[31:0]) begin
      miscompares++;
      $display("FAIL sw_instret: got %0d, need %0d", bus.instret, model_ret);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [3];
    bit r;
    fns[0] = 6'b101010; fns[1] = 6'b100010; fns[2] = 6'b111000;
    for (int k = 0; k < 3; k++) begin
      bus.op = T_R; bus.funct = fns[k];
      r = build(T_R, fns[k], 1'b0, 0, 0);
      run_seq(exp_q.size());
      foreach (exp_q[i]) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rtype funct=%b cycle %0d: got %h, need %h", fns[k], i, obs_q[i], exp_q[i]);
        end
      end
      if (r) model_ret++;
    end
    vectors++;
    if (bus.instret !== model_ret[31:0]) begin
      miscompares++;
      $display("FAIL rtype_instret: got %0d, need %0d", bus.instret, model_ret);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [4];
    logic zs [4];
    bit r;
    ops[0] = T_BEQ; zs[0] = 1'b1;
    ops[1] = T_BNE; zs[1] = 1'b1;
    ops[2] = T_BNE; zs[2] = 1'b0;
    ops[3] = T_BEQ; zs[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.op = ops[k]; bus.zero = zs[k];
      r = build(ops[k], 6'b0, zs[k], 0, 0);
      run_seq(exp_q.size());
      foreach (exp_q[i]) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL branch op=%b zero=%b cycle %0d: got %h, need %h", ops[k], zs[k], i, obs_q[i], exp_q[i]);
        end
      end
      if (r) model_ret++;
    end
  endtask

  task automatic test_illegal();
    bit r;
    bus.op = 6'b111111;
    r = build(6'b111111, 6'b0, 1'b0, 0, 0);
    run_seq(exp_q.size());
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL illegal_op cycle %0d: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (r) model_ret++;
    vectors++;
    if (bus.instret !== model_ret[31:0]) begin
      miscompares++;
      $display("FAIL illegal_instret: got %0d, need %0d", bus.instret, model_ret);
    end
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    logic z;
    bit r;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0: op = T_LW;
        1: op = T_SW;
        2: op = T_R;
        3: op = T_BEQ;
        4: op = T_BNE;
        5: op = T_ADDI;
        6: op = T_J;
        default: op = 6'b010000 | 6'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 5))
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        4: fn = 6'b101010;
        default: fn = 6'($urandom);
      endcase
      z = 1'($urandom);
      bus.op = op; bus.funct = fn; bus.zero = z;
      r = build(op, fn, z, $urandom_range(0, 2), $urandom_range(0, 2));
      run_seq(exp_q.size());
      foreach (exp_q[i]) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL random #%0d op=%b funct=%b zero=%b cycle %0d: got %h, need %h", n, op, fn, z, i, obs_q[i], exp_q[i]);
        end
      end
      if (r) model_ret++;
      vectors++;
      if (bus.instret !== model_ret[31:0] || bus4.instret !== model_ret[3:0]) begin
        miscompares++;
        $display("FAIL random #%0d instret: got %0d/%0d, need %0d", n, bus.instret, bus4.instret, model_ret);
      end
    end
  endtask

  task automatic test_async_reset();
    bit r;
    bus.op = T_SW;
    r = build(T_SW, 6'b0, 1'b0, 0, 2);
    run_seq(4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL async_pre cycle %0d: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    bus.memready = 1'b0;
    #2;
    vectors++;
    if (bus.memwrite !== 1'b1) begin
      miscompares++;
      $display("FAIL async_memwr_held: got memwrite=%b, need 1", bus.memwrite);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.memwrite !== 1'b0 || bus.irwrite !== 1'b0 || bus.pcen !== 1'b0 ||
        bus.regwrite !== 1'b0 || bus.instret !== 32'd0 || bus4.instret !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset: got mw=%b ir=%b pcen=%b rw=%b instret=%0d/%0d, need all 0",
               bus.memwrite, bus.irwrite, bus.pcen, bus.regwrite, bus.instret, bus4.instret);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_ret = 0;
    bus.op = T_J;
    r = build(T_J, 6'b0, 1'b0, 0, 0);
    run_seq(exp_q.size());
    foreach (exp_q[i]) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL async_post cycle %0d: got %h, need %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (r) model_ret++;
    vectors++;
    if (bus.instret !== 32'd1) begin
      miscompares++;
      $display("FAIL async_post_instret: got %0d, need 1", bus.instret);
    end
  endtask

  task automatic test_wrap();
    bit r;
    do_reset();
    bus.op = T_J;
    for (int n = 0; n < 16; n++) begin
      r = build(T_J, 6'b0, 1'b0, $urandom_range(0, 1), 0);
      run_seq(exp_q.size());
      foreach (exp_q[i]) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL wrap j#%0d cycle %0d: got %h, need %h", n, i, obs_q[i], exp_q[i]);
        end
      end
      if (r) model_ret++;
    end
    vectors++;
    if (bus4.instret !== 4'd0 || bus.instret !== 32'd16) begin
      miscompares++;
      $display("FAIL wrap_instret: got %0d (4-bit) %0d (32-bit), need 0 and 16", bus4.instret, bus.instret);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_branch();
    test_illegal();
    test_random();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
